lsu_ready_tracker: RTL and testbench

- Cycle-level behavioural model of the CVA6 load/store unit's issue-side readiness.
- Accepts one load or store per cycle from the issue stage.
- Tracks at most one outstanding load and a FIFO store queue that drains on memory responses.
- Drives ready_o so the issue stage stalls on structural hazards and on load-after-store address hazards.

---
 rtl/lsu_ready_tracker.sv | 122 ++++++++++++
 tb/tb_lsu_ready_tracker.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_ready_tracker.sv
// Issue-side readiness of the load/store unit: one outstanding load plus a FIFO store queue.
// Build macro LSU_STORE_FWD_EN: a load hitting a queued store is forwarded rather than stalled.
module lsu_ready_tracker #(
  parameter int unsigned STQ_DEPTH = 4,
  parameter int unsigned OFFSET_W  = 12
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic        is_load_i,
  input  logic        instr_valid_i,
  input  logic        store_mem_resp_i,
  input  logic        load_mem_resp_i,
  output logic        ready_o
);

  localparam int unsigned PTR_W = $clog2(STQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_STORE = 2'd1,
    ISSUED     = 2'd2
  } load_state_e;

  load_state_e         state_q, state_d;
  logic [OFFSET_W-1:0] stq_data [STQ_DEPTH];
  logic [STQ_DEPTH-1:0] stq_valid;
  logic [PTR_W-1:0]    head_q, tail_q;
  logic [CNT_W-1:0]    count_q;
  logic [OFFSET_W-1:0] offset;
  logic                fire, push, pop, issue_match;
  logic                unused_instr;

  assign offset       = instr_i[OFFSET_W-1:0];
  assign unused_instr = ^instr_i[31:OFFSET_W];
  assign fire         = instr_valid_i & ready_o;
  assign push         = fire & ~is_load_i;
  assign pop          = store_mem_resp_i & (count_q != '0);

  // Hazard check against the queue as it stood before this cycle's pop.
  always_comb begin
    // NOTE: default first so no path leaves the variable unassigned (no latch).
    issue_match = 1'b0;
    for (int i = 0; i < int'(STQ_DEPTH); i++)
      if (stq_valid[i] && stq_data[i] == offset) issue_match = 1'b1;
  end

`ifndef LSU_STORE_FWD_EN
  logic [OFFSET_W-1:0] wait_offset_q;
  logic                wait_match;

  always_comb begin
    wait_match = 1'b0;
    for (int i = 0; i < int'(STQ_DEPTH); i++)
      if (stq_valid[i] && stq_data[i] == wait_offset_q) wait_match = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                   wait_offset_q <= '0;
    else if (state_q == IDLE && fire && is_load_i) wait_offset_q <= offset;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (fire && is_load_i) begin
`ifdef LSU_STORE_FWD_EN
          state_d = issue_match ? IDLE : ISSUED;
`else
          state_d = issue_match ? WAIT_STORE : ISSUED;
`endif
        end
      end
      WAIT_STORE: begin
`ifndef LSU_STORE_FWD_EN
        if (!wait_match) state_d = ISSUED;
`endif
      end
      ISSUED:  if (load_mem_resp_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state_q == IDLE) && (count_q < CNT_W'(STQ_DEPTH));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      stq_valid <= '0;
    end else begin
      if (pop) begin
        stq_valid[head_q] <= 1'b0;
        head_q            <= head_q + PTR_W'(1);
      end
      if (push) begin
        stq_valid[tail_q] <= 1'b1;
        tail_q            <= tail_q + PTR_W'(1);
      end
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

  // NOTE: payload storage is not reset; the reset valid bits make stale contents invisible.
  always_ff @(posedge clk_i) begin
    if (push) stq_data[tail_q] <= offset;
  end

endmodule

// File: tb/tb_lsu_ready_tracker.sv
// Self-checking bench for lsu_ready_tracker: directed vector table, hand-written reset sequence,
// then randomized traffic compared cycle by cycle against a queue-based reference model.
module tb_lsu_ready_tracker;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] instr_i;
  logic        is_load_i, instr_valid_i, store_mem_resp_i, load_mem_resp_i;
  logic        ready_o;

  int n_checks = 0;
  int n_pass   = 0;

  lsu_ready_tracker #(.STQ_DEPTH(DEPTH), .OFFSET_W(12)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .instr_i         (instr_i),
    .is_load_i       (is_load_i),
    .instr_valid_i   (instr_valid_i),
    .store_mem_resp_i(store_mem_resp_i),
    .load_mem_resp_i (load_mem_resp_i),
    .ready_o         (ready_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        v;
    logic        ld;
    logic [11:0] off;
    logic        sr;
    logic        lr;
    logic        exp_ready;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic actual, input logic expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: ready_o=%b expected=%b at t=%0t", name, actual, expected, $time);
  endtask

  function automatic void add(input logic v, input logic ld, input logic [11:0] off,
                              input logic sr, input logic lr, input logic exp_ready,
                              input string name);
    vec_t e;
    e.v = v; e.ld = ld; e.off = off; e.sr = sr; e.lr = lr;
    e.exp_ready = exp_ready; e.name = name;
    vecs.push_back(e);
  endfunction

  task automatic drive(input logic v, input logic ld, input logic [11:0] off,
                       input logic sr, input logic lr);
    instr_valid_i    = v;
    is_load_i        = ld;
    instr_i          = {$urandom_range(0, 1048575), off};
    store_mem_resp_i = sr;
    load_mem_resp_i  = lr;
  endtask

  // Drive for one clock and sample the result on the following falling edge.
  task automatic step(input logic v, input logic ld, input logic [11:0] off,
                      input logic sr, input logic lr, input logic exp_ready,
                      input string name);
    drive(v, ld, off, sr, lr);
    @(negedge clk_i);
    check(name, ready_o, exp_ready);
  endtask

  // Reference model: a plain queue of offsets plus "load outstanding" / "load blocked" flags.
  logic [11:0] m_q[$];
  bit          m_busy, m_blocked;
  logic [11:0] m_off;

  function automatic bit m_hit(input logic [11:0] off);
    foreach (m_q[i]) if (m_q[i] == off) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ready();
    return !m_busy && (m_q.size() < DEPTH);
  endfunction

  function automatic void m_update();
    bit fire, hit, busy_n, blocked_n;
    fire      = instr_valid_i && m_ready();
    hit       = m_hit(instr_i[11:0]);
    busy_n    = m_busy;
    blocked_n = m_blocked;
    if (m_busy && m_blocked) begin
      if (!m_hit(m_off)) blocked_n = 1'b0;
    end else if (m_busy && load_mem_resp_i) begin
      busy_n = 1'b0;
    end
    if (fire && is_load_i) begin
`ifdef LSU_STORE_FWD_EN
      if (!hit) begin busy_n = 1'b1; blocked_n = 1'b0; end
`else
      busy_n    = 1'b1;
      blocked_n = hit;
      m_off     = instr_i[11:0];
`endif
    end
    if (store_mem_resp_i && m_q.size() > 0) void'(m_q.pop_front());
    if (fire && !is_load_i) m_q.push_back(instr_i[11:0]);
    m_busy    = busy_n;
    m_blocked = blocked_n;
  endfunction

  initial begin
    rst_i = 1'b1;
    drive(0, 0, 12'h000, 0, 0);
    #2 check("ready_during_reset", ready_o, 1'b1);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    for (int i = 0; i < 10; i++) add(0, 0, 12'h000, 0, 0, 1, "idle_ready");
    add(1, 1, 12'hCAD, 0, 0, 0, "load_issued");
    add(0, 0, 12'h000, 0, 0, 0, "load_wait1");
    add(0, 0, 12'h000, 0, 0, 0, "load_wait2");
    add(0, 0, 12'h000, 0, 1, 1, "load_resp_ready");
    add(1, 0, 12'hCAD, 0, 0, 1, "store_cad");
`ifdef LSU_STORE_FWD_EN
    add(1, 1, 12'hCAD, 0, 0, 1, "load_fwd_ready");
    add(0, 0, 12'h000, 0, 1, 1, "stray_lresp_ignored");
    add(0, 0, 12'h000, 1, 0, 1, "store_drained");
`else
    add(1, 1, 12'hCAD, 0, 0, 0, "load_hazard_stall");
    add(0, 0, 12'h000, 0, 1, 0, "lresp_in_wait_ignored");
    add(0, 0, 12'h000, 1, 0, 0, "store_pop_still_busy");
    add(0, 0, 12'h000, 0, 0, 0, "wait_to_issued");
    add(0, 0, 12'h000, 0, 1, 1, "lresp_after_issue");
`endif
    add(0, 0, 12'h000, 1, 0, 1, "sresp_empty_ignored");
    add(1, 0, 12'h100, 0, 0, 1, "store_100");
    add(1, 0, 12'h101, 0, 0, 1, "store_101");
    add(1, 0, 12'h102, 0, 0, 1, "store_102");
    add(1, 0, 12'h103, 0, 0, 0, "queue_full");
    add(1, 0, 12'h1FF, 0, 0, 0, "store_when_full_dropped");
    add(0, 0, 12'h000, 1, 0, 1, "pop_frees_slot");
    add(1, 0, 12'h104, 1, 0, 1, "push_pop_same_cycle");
    add(1, 0, 12'h105, 0, 0, 0, "refill_full");

    foreach (vecs[i]) step(vecs[i].v, vecs[i].ld, vecs[i].off, vecs[i].sr, vecs[i].lr,
                           vecs[i].exp_ready, vecs[i].name);

    // Reset with a load outstanding and two stores queued.
    for (int i = 0; i < DEPTH; i++) step(0, 0, 12'h000, 1, 0, 1, "drain");
    step(1, 0, 12'h200, 0, 0, 1, "rst_seq_store0");
    step(1, 0, 12'h201, 0, 0, 1, "rst_seq_store1");
    step(1, 1, 12'h300, 0, 0, 0, "rst_seq_load");
    drive(0, 0, 12'h000, 0, 0);
    rst_i = 1'b1;
    #1 check("ready_immediately_on_reset", ready_o, 1'b1);
    @(negedge clk_i);
    rst_i = 1'b0;
    step(0, 0, 12'h000, 1, 0, 1, "post_reset_sresp");
    step(1, 0, 12'h400, 0, 0, 1, "post_reset_store0");
    step(1, 0, 12'h401, 0, 0, 1, "post_reset_store1");
    step(1, 0, 12'h402, 0, 0, 1, "post_reset_store2");
    step(1, 0, 12'h403, 0, 0, 0, "post_reset_full");

    // Randomized traffic against the reference model.
    drive(0, 0, 12'h000, 0, 0);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    m_q.delete();
    m_busy = 1'b0;
    m_blocked = 1'b0;
    m_off = '0;
    for (int i = 0; i < 3000; i++) begin
      check("random_ready", ready_o, m_ready());
      drive(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 40),
            12'h0A0 + 12'($urandom_range(0, 3)),
            ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 25));
      @(posedge clk_i);
      m_update();
      @(negedge clk_i);
    end
    check("random_final", ready_o, m_ready());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
